// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared opcode, field and FSM state definitions
package instruction_fetch_pkg;

  localparam int INSTR_W     = 28;
  localparam int OP_MSB      = 27;
  localparam int OP_LSB      = 24;
  localparam int JMP_TGT_MSB = 23;
  localparam int JMP_TGT_LSB = 16;
  localparam int NOP_CNT_MSB = 23;
  localparam int NOP_CNT_LSB = 0;
  localparam int DELAY_W     = NOP_CNT_MSB - NOP_CNT_LSB + 1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_STO = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_BLE = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DELAY = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/delay_counter.sv
// rtl/delay_counter.sv - loadable down-counter timing NOP bubbles
import instruction_fetch_pkg::*;

module delay_counter (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_value,
  input  logic               dec_en,
  output logic               terminal
);

  logic [DELAY_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec_en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Terminal marks the last bubble: decrementing from 1 ends the delay.
  assign terminal = (count == DELAY_W'(1));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC sequencing with JMP, NOP delay, stall and branch redirect
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter int          ADDR_W     = 16,
  parameter logic [15:0] RESET_ADDR = 16'd0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [ADDR_W-1:0]  oAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic               oDelayBusy
);

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  opc_n;
  logic               valid_n;
  logic               busy_n;
  logic               cnt_load;
  logic [DELAY_W-1:0] cnt_value;
  logic               cnt_dec;
  logic               cnt_terminal;
  logic [3:0]         opcode;
  logic [DELAY_W-1:0] nop_count;

  assign oAddress  = pc;
  assign opcode    = get_opcode(iInstruction);
  assign nop_count = iInstruction[NOP_CNT_MSB:NOP_CNT_LSB];

  delay_counter u_delay_counter (
    .clk        (Clock),
    .rst        (Reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec_en     (cnt_dec),
    .terminal   (cnt_terminal)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_FETCH;
      pc           <= ADDR_W'(RESET_ADDR);
      oInstruction <= '0;
      oPC          <= '0;
      oValid       <= 1'b0;
      oDelayBusy   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      oInstruction <= instr_n;
      oPC          <= opc_n;
      oValid       <= valid_n;
      oDelayBusy   <= busy_n;
    end
  end

  // Busy is registered so it lines up with the bubble cycles seen downstream.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = oInstruction;
    opc_n     = oPC;
    valid_n   = oValid;
    busy_n    = oDelayBusy;
    cnt_load  = 1'b0;
    cnt_value = '0;
    cnt_dec   = 1'b0;

    if (iBranchTaken) begin
      pc_n     = iBranchTarget;
      state_n  = ST_FETCH;
      valid_n  = 1'b0;
      busy_n   = 1'b0;
      cnt_load = 1'b1;
    end else if (!iStall) begin
      case (state)
        ST_FETCH: begin
          busy_n = 1'b0;
          if (opcode == OP_JMP) begin
            pc_n    = ADDR_W'(iInstruction[JMP_TGT_MSB:JMP_TGT_LSB]);
            valid_n = 1'b0;
          end else begin
            instr_n = iInstruction;
            opc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc + 1'b1;
            if (opcode == OP_NOP && nop_count != '0) begin
              state_n   = ST_DELAY;
              cnt_load  = 1'b1;
              cnt_value = nop_count;
            end
          end
        end
        ST_DELAY: begin
          valid_n = 1'b0;
          busy_n  = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_terminal) begin
            state_n = ST_FETCH;
          end
        end
        default: state_n = ST_FETCH;
      endcase
    end
  end

endmodule
